// File: rtl/fdq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fdq_pkg
//  Description : Shared types, constants and width helpers for the
//                fetch/decode queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package fdq_pkg;

    localparam int          FDQ_XLEN  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [FDQ_XLEN-1:0] instr;
        logic [FDQ_XLEN-1:0] pc;
        logic [FDQ_XLEN-1:0] pc_plus_four;
    } fdq_entry_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fdq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fdq_fifo
//  Description : Circular entry store with read/write pointers, separate
//                occupancy count and synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module fdq_fifo
    import fdq_pkg::*;
#(
    parameter int  DEPTH     = 4,
    parameter type T         = fdq_entry_t,
    localparam int c_ptr_w   = $clog2(DEPTH),
    localparam int c_count_w = count_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  T                     wr_data,
    output T                     rd_data,
    output logic [c_count_w-1:0] count,
    output logic                 full
);

    T                     r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_count_w-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_count_w'(DEPTH));
    assign w_do_pop  = pop && !w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_count_w'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_count_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !clear) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign full    = w_full;

endmodule
`default_nettype wire

// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_queue
//  Description : DEPTH-entry instruction queue plus decode output register
//                with bypass, stall hold and branch flush. Define
//                FDQ_STATS_EN to add flush-kill and stall-cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_queue
    import fdq_pkg::*;
#(
    parameter int              XLEN      = FDQ_XLEN,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fdq_pkg::NOP_INSTR),
    localparam int             c_count_w = count_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  logic [XLEN-1:0]      instruction_in,
    input  logic [XLEN-1:0]      pc_in,
    input  logic [XLEN-1:0]      pc_plus_four_in,
    output logic                 full,
    input  logic                 stall,
    output logic [XLEN-1:0]      instruction,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      pc_plus_four,
    output logic                 valid,
    output logic [c_count_w-1:0] count
`ifdef FDQ_STATS_EN
    ,
    output logic [15:0]          flush_kill_count,
    output logic [15:0]          stall_cycle_count
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_four;
    } entry_t;

    entry_t               w_in_entry;
    entry_t               w_head;
    logic [c_count_w-1:0] w_count;
    logic                 w_full;
    logic                 w_advance;
    logic                 w_pop;
    logic                 w_bypass;
    logic                 w_fifo_push;

    logic                 r_valid;
    logic [XLEN-1:0]      r_instr;
    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_pc_plus_four;

    assign w_in_entry = '{instr: instruction_in, pc: pc_in, pc_plus_four: pc_plus_four_in};

    assign w_advance   = ~stall;
    assign w_pop       = w_advance && !flush && (w_count != '0);
    // An empty queue lets the fetched entry go straight to the output slot.
    assign w_bypass    = w_advance && !flush && (w_count == '0) && push;
    assign w_fifo_push = push && !flush && !w_bypass;

    fdq_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .push    (w_fifo_push),
        .pop     (w_pop),
        .wr_data (w_in_entry),
        .rd_data (w_head),
        .count   (w_count),
        .full    (w_full)
    );

    // pc fields deliberately hold across NOP loads and flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid        <= 1'b0;
            r_instr        <= NOP_INSTR;
            r_pc           <= '0;
            r_pc_plus_four <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (w_advance) begin
            if (w_pop) begin
                r_valid        <= 1'b1;
                r_instr        <= w_head.instr;
                r_pc           <= w_head.pc;
                r_pc_plus_four <= w_head.pc_plus_four;
            end else if (w_bypass) begin
                r_valid        <= 1'b1;
                r_instr        <= instruction_in;
                r_pc           <= pc_in;
                r_pc_plus_four <= pc_plus_four_in;
            end else begin
                r_valid <= 1'b0;
                r_instr <= NOP_INSTR;
            end
        end
    end

`ifdef FDQ_STATS_EN
    logic [15:0] r_flush_kill_count;
    logic [15:0] r_stall_cycle_count;
    logic [16:0] w_kill_sum;

    assign w_kill_sum = {1'b0, r_flush_kill_count} + 17'(w_count) + 17'(r_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flush_kill_count  <= '0;
            r_stall_cycle_count <= '0;
        end else begin
            if (flush) begin
                r_flush_kill_count <= w_kill_sum[16] ? 16'hFFFF : w_kill_sum[15:0];
            end
            if (stall && r_valid && (r_stall_cycle_count != 16'hFFFF)) begin
                r_stall_cycle_count <= r_stall_cycle_count + 16'd1;
            end
        end
    end

    assign flush_kill_count  = r_flush_kill_count;
    assign stall_cycle_count = r_stall_cycle_count;
`endif

    assign full         = w_full;
    assign count        = w_count;
    assign valid        = r_valid;
    assign instruction  = r_instr;
    assign pc           = r_pc;
    assign pc_plus_four = r_pc_plus_four;

endmodule
`default_nettype wire

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Parametrised successor to the fetch/decode boundary register. It combines a DEPTH-entry instruction queue with an output register that feeds decode. It decouples fetch from decode stalls (L1 busy) and flushes all in-flight entries on a taken branch. Empty slots present a NOP with valid low, so decode always sees a legal instruction.

Parameters:
XLEN, 32, width of instruction, pc and pc_plus_four fields
DEPTH, 4, queue entries behind the output register; power of 2, at least 2
NOP_INSTR, 32'h00000013, instruction driven whenever the output slot is empty (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  taken branch/redirect; kills queue and output slot
push  in  1  fetch presents an entry this cycle
instruction_in  in  XLEN  fetched instruction
pc_in  in  XLEN  pc of fetched instruction
pc_plus_four_in  in  XLEN  pc+4 of fetched instruction
full  out  1  queue cannot accept push this cycle
stall  in  1  decode hold (L1_busy); output register frozen when high
instruction  out  XLEN  instruction to decode
pc  out  XLEN  pc to decode
pc_plus_four  out  XLEN  pc+4 to decode
valid  out  1  output slot holds a real instruction
count  out  $clog2(DEPTH+1)  occupied queue entries, excluding the output slot

Behaviour:
- Reset clk domain: reset is asynchronous, active-high; clock is clk. On reset: instruction=NOP_INSTR, pc=0, pc_plus_four=0, valid=0, count=0, full=0, queue pointers=0.
- full = (count==DEPTH), combinational from registered count. A push while full is ignored and the entry is dropped; fetch must hold.
- advance = ~stall. On an advance cycle without flush, the output register loads in this priority order:
  - the queue head (pop), if count>0;
  - otherwise the bypass from the *_in inputs, if push is high; that entry does not enter the queue; latency push->output is 1 cycle;
  - otherwise NOP_INSTR with valid=0. pc and pc_plus_four hold their previous values.
- On a stall cycle the output register holds all fields. A push with count<DEPTH writes the queue.
- Simultaneous push and pop with count>0: the head is popped and the push is written to the tail. count is unchanged, and this is allowed even when full is high, since full is asserted but the pop frees a slot. full remains combinational, so fetch sees full=1 and holds. Exact-full push+pop acceptance is therefore never exercised, which keeps timing simple.
- Pointer wrap: read/write pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately.
- flush has the highest priority and takes effect regardless of stall:
  - next cycle instruction=NOP_INSTR, valid=0, count=0, pointers reset;
  - a push in the flush cycle is discarded;
  - pc and pc_plus_four hold.
- There is no internal FSM beyond the queue. Occupancy states are EMPTY (count 0), PARTIAL and FULL, driven only by push, advance and flush as above.

Optional Feature:
FDQ_STATS_EN
- Defined: adds outputs flush_kill_count (16b) and stall_cycle_count (16b).
  - flush_kill_count adds count+valid on every flush.
  - stall_cycle_count increments each cycle stall=1 && valid=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and logic absent; block behaviour otherwise identical.

Decomposition:
- Package fdq_pkg:
  - fdq_entry_t packed struct {instr, pc, pc_plus_four} parameterised via XLEN=32 default;
  - localparam NOP_INSTR;
  - function clog2-based COUNT_W helper.
- Sub-module fdq_fifo:
  - storage array of fdq_entry_t with rd/wr pointers, count, push/pop/clear;
  - no bypass logic.
- The top holds the output register, bypass mux and flush/stall priority.

Test Plan:
- Reset mid-stream (count=3, valid=1) -> same cycle instruction=32'h00000013, valid=0, count=0, full=0.
- Push 0x00500093@pc 0x100 into empty queue, stall=0 -> next cycle instruction=0x00500093, pc=0x100, pc_plus_four=0x104, valid=1, count=0 (bypass).
- stall=1 for 6 cycles with 6 pushes, DEPTH=4 -> full=1 after 4 pushes, count=4. Pushes 5-6 are dropped. The output register is unchanged throughout. Releasing stall pops in FIFO order over 4 cycles.
- count=2 with push and advance in the same cycle -> head appears at output, count stays 2, and the new entry emerges after the older one.
- flush with stall=1, count=3, push=1 -> next cycle valid=0, instruction=NOP, count=0. The pushed entry never appears.
- Pointer wrap: 10 push/pop pairs through DEPTH=4 with a varying stall pattern -> output sequence equals input sequence, with no duplicates or losses.
